// File: rtl/mmio_trace_port.sv
// MMIO trace port: snoops core bus accesses in the 0x800 window into a FWFT FIFO
// and stops capturing once the halt address has been touched.
module mmio_trace_port #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] HALT_ADDR = 32'h00000FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_out,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic        trace_we,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [6:0]  level,
  output logic [15:0] drop_cnt,
  output logic        halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0]    FULL    = 7'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  generate
    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mmio_trace_port: DEPTH must be a power of two in 2..64");
    end
  endgenerate

  typedef enum logic {S_RUN, S_HALT} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  state_t        state_q, state_d;
  rec_t          mem [DEPTH];
  rec_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          capture_en;
  logic          capture, push, pop, drop;

  // State register: reset returns to RUN from anywhere.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // Next-state: the halt address is checked regardless of address[11].
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (address == HALT_ADDR) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    halted     = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      S_RUN:   capture_en = 1'b1;
      S_HALT:  halted     = 1'b1;
      default: capture_en = 1'b0;
    endcase
  end

  // A full FIFO still accepts a capture when the same edge pops an entry.
  always_comb begin
    capture = capture_en && address[11] && (address != HALT_ADDR);
    pop     = (level != 7'd0) && trace_ready;
    push    = capture && ((level != FULL) || pop);
    drop    = capture && (level == FULL) && !pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + 7'd1;
        2'b01:   level <= level - 7'd1;
        default: level <= level;
      endcase
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible because
  // the outputs are forced to zero whenever level is zero.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{we: we, addr: address, data: (we ? data_out : data_in)};
    end
  end

  // First-word-fall-through: the head entry is shown combinationally.
  always_comb begin
    head        = mem[rd_ptr];
    trace_valid = (level != 7'd0);
    trace_we    = 1'b0;
    trace_addr  = '0;
    trace_data  = '0;
    if (trace_valid) begin
      trace_we   = head.we;
      trace_addr = head.addr;
      trace_data = head.data;
    end
  end

endmodule

// File: tb/tb_mmio_trace_port.sv
// Directed bench for mmio_trace_port at DEPTH=8: capture, filter, overflow,
// full push-and-pop, halt and mid-stream reset.
module tb_mmio_trace_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, data_out, data_in;
  logic        we;
  logic        trace_valid, trace_ready, trace_we;
  logic [31:0] trace_addr, trace_data;
  logic [6:0]  level;
  logic [15:0] drop_cnt;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_trace_port #(.DEPTH(8), .HALT_ADDR(32'h00000FFC)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .data_out   (data_out),
    .data_in    (data_in),
    .we         (we),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_we   (trace_we),
    .trace_addr (trace_addr),
    .trace_data (trace_data),
    .level      (level),
    .drop_cnt   (drop_cnt),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    address  = 32'h0;
    we       = 1'b0;
    data_out = 32'h0;
    data_in  = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    address  = a;
    we       = 1'b1;
    data_out = d;
    step();
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 32'(trace_valid), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_addr"},  trace_addr, 32'h0);
    check({tag, "_data"},  trace_data, 32'h0);
    check({tag, "_we"},    32'(trace_we), 32'd0);
  endtask

  initial begin
    idle();
    trace_ready = 1'b0;
    reset       = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_empty("rst");
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_halt", 32'(halted), 32'd0);

    // Store capture with an eager consumer.
    trace_ready = 1'b1;
    store(32'h800, 32'h12345678);
    idle();
    check("st_valid", 32'(trace_valid), 32'd1);
    check("st_we",    32'(trace_we), 32'd1);
    check("st_addr",  trace_addr, 32'h800);
    check("st_data",  trace_data, 32'h12345678);
    check("st_level", 32'(level), 32'd1);
    step();
    check("st_pop_level", 32'(level), 32'd0);
    check("st_pop_valid", 32'(trace_valid), 32'd0);

    // Load capture followed by an access outside the window.
    trace_ready = 1'b0;
    address = 32'h804; we = 1'b0; data_in = 32'hCAFEBABE;
    step();
    address = 32'h004; we = 1'b1; data_out = 32'h11111111;
    step();
    idle();
    check("ld_level", 32'(level), 32'd1);
    check("ld_we",    32'(trace_we), 32'd0);
    check("ld_addr",  trace_addr, 32'h804);
    check("ld_data",  trace_data, 32'hCAFEBABE);
    trace_ready = 1'b1;
    step();
    check("ld_pop_level", 32'(level), 32'd0);
    trace_ready = 1'b0;

    // Overflow: ten stores into eight slots.
    for (int i = 0; i < 10; i++) store(32'h800 + 32'(4 * i), 32'(i));
    idle();
    check("ov_level", 32'(level), 32'd8);
    check("ov_drop",  32'(drop_cnt), 32'd2);
    check("ov_head",  trace_data, 32'd0);
    step();
    check("ov_stable_addr", trace_addr, 32'h800);

    // Full push-and-pop keeps level at 8 without a drop.
    trace_ready = 1'b1;
    store(32'h900, 32'h900);
    idle();
    check("pp_level", 32'(level), 32'd8);
    check("pp_drop",  32'(drop_cnt), 32'd2);
    for (int j = 1; j < 8; j++) begin
      check($sformatf("dr_data%0d", j), trace_data, 32'(j));
      check($sformatf("dr_addr%0d", j), trace_addr, 32'h800 + 32'(4 * j));
      step();
    end
    check("dr_last_addr", trace_addr, 32'h900);
    check("dr_last_data", trace_data, 32'h900);
    step();
    check("dr_empty", 32'(trace_valid), 32'd0);

    // Halt with three queued records.
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'hA00 + 32'(4 * i), 32'h100 + 32'(i));
    address = 32'hFFC; we = 1'b0;
    step();
    check("h_halted", 32'(halted), 32'd1);
    check("h_level",  32'(level), 32'd3);
    store(32'h808, 32'hDEAD);
    idle();
    check("h_nocap", 32'(level), 32'd3);
    check("h_head",  trace_addr, 32'hA00);
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("h_dr%0d", i), trace_data, 32'h100 + 32'(i));
      step();
    end
    check("h_empty",  32'(trace_valid), 32'd0);
    check("h_sticky", 32'(halted), 32'd1);

    // Reset mid-stream with level=5 and halted=1.
    trace_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) store(32'hB00 + 32'(4 * i), 32'(i));
    address = 32'hFFC; we = 1'b0;
    step();
    idle();
    check("mr_level",  32'(level), 32'd5);
    check("mr_halted", 32'(halted), 32'd1);
    address = 32'h800; we = 1'b1; data_out = 32'h77;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    check_empty("mr");
    check("mr_drop", 32'(drop_cnt), 32'd0);
    check("mr_halt", 32'(halted), 32'd0);
    store(32'h800, 32'h55);
    idle();
    check("post_valid", 32'(trace_valid), 32'd1);
    check("post_addr",  trace_addr, 32'h800);
    check("post_data",  trace_data, 32'h55);

    // Held address produces one record per cycle.
    for (int i = 0; i < 2; i++) store(32'h800, 32'h55);
    idle();
    check("hold_level", 32'(level), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_trace_port.md
MMIO_TRACE_PORT -- requirements
Module: mmio_trace_port

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the FIFO entry count; only a power of two from 2 to 64 is legal.
REQ-002 Parameter HALT_ADDR, default 32'h00000FFC, SHALL set the address that terminates tracing.
REQ-003 Port clk, input, 1 bit: the only clock. One clock; reset is synchronous and active-high.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port address, input, 32 bits: core bus address.
REQ-006 Port data_out, input, 32 bits: core store data.
REQ-007 Port data_in, input, 32 bits: memory read data returned to the core.
REQ-008 Port we, input, 1 bit: core write strobe.
REQ-009 Port trace_valid, output, 1 bit: a trace record is presented.
REQ-010 Port trace_ready, input, 1 bit: the consumer accepts the record.
REQ-011 Port trace_we, output, 1 bit: 1 marks a store record and 0 marks a load record.
REQ-012 Port trace_addr, output, 32 bits: address of the record.
REQ-013 Port trace_data, output, 32 bits: store data or load data of the record.
REQ-014 Port level, output, 7 bits: current FIFO occupancy.
REQ-015 Port drop_cnt, output, 16 bits: count of records lost to overflow.
REQ-016 Port halted, output, 1 bit: sticky indication that HALT_ADDR was seen.

Function
REQ-017 A capture SHALL occur on every rising edge with address[11]==1, address!=HALT_ADDR, halted==0 and reset==0.
REQ-018 A capture SHALL record {we, address, we ? data_out : data_in}, sampled at that edge.
REQ-019 A bus held on the same address for N cycles SHALL produce N records; no de-duplication is performed.
REQ-020 Records SHALL be stored in a DEPTH-entry FIFO with first-word-fall-through output.
REQ-021 trace_* SHALL show the oldest entry whenever level>0.
REQ-022 trace_valid SHALL equal (level!=0).
REQ-023 A pop SHALL occur on a rising edge with trace_valid==1 and trace_ready==1.
REQ-024 trace_addr, trace_data and trace_we SHALL remain stable while trace_valid==1 and trace_ready==0.
REQ-025 Latency: a record captured at edge k SHALL appear on trace_* after edge k when the FIFO was empty, so trace_valid==1 in cycle k+1.
REQ-026 A push and a pop on the same edge SHALL leave level unchanged, including when level==DEPTH.
REQ-027 A capture with level==DEPTH and no simultaneous pop SHALL be discarded, leaving the FIFO contents unchanged.
REQ-028 Each discarded capture SHALL increment drop_cnt, which saturates at 16'hFFFF.
REQ-029 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-030 level SHALL be a separate counter ranging from 0 to DEPTH.
REQ-031 A rising edge with address==HALT_ADDR SHALL set halted to 1 from the next cycle.
REQ-032 The halting access itself SHALL NOT be captured.
REQ-033 Once halted==1, captures SHALL stop.
REQ-034 Once halted==1, draining via trace_ready SHALL continue until level==0.
REQ-035 halted SHALL clear only on reset.
REQ-036 Accesses with address[11]==0 SHALL be ignored, except the HALT_ADDR check.
REQ-037 State machine: RUN (captures enabled) -> HALT on a HALT_ADDR edge; HALT persists; reset -> RUN from any state.

Reset
REQ-038 With reset==1 at a rising edge, the block SHALL clear level, both pointers, drop_cnt and halted, and enter RUN.
REQ-039 During and after reset, trace_valid SHALL be 0.
REQ-040 No capture SHALL occur on an edge where reset==1.
REQ-041 Reset asserted mid-operation SHALL flush all FIFO contents without emitting them.
REQ-042 trace_addr, trace_data and trace_we SHALL be 0 while level==0 after reset.

Verification
REQ-043 Store capture: trace_ready=1; one cycle with address=0x800, we=1, data_out=0x12345678 -> in the next cycle trace_valid=1, trace_we=1, trace_addr=0x800, trace_data=0x12345678; level returns to 0 after the pop.
REQ-044 Load and filter: address=0x804, we=0, data_in=0xCAFEBABE, then address=0x004 with we=1 -> exactly one record {0, 0x804, 0xCAFEBABE}; no record for 0x004.
REQ-045 Overflow: trace_ready=0; 10 consecutive store cycles to 0x800+4i with data i at DEPTH=8 -> level=8 and drop_cnt=2; draining yields data 0..7 in order.
REQ-046 Full push-and-pop: at level=8, trace_ready=1 together with a new store 0x900 -> level stays 8, drop_cnt is unchanged, and 0x900 is the last record drained.
REQ-047 Halt: 3 records queued, then address=0xFFC, then a store to 0x808 -> halted=1, the 0x808 store is not recorded, and the 3 records drain before trace_valid falls to 0.
REQ-048 Reset mid-stream: level=5 and halted=1, then reset for 1 cycle -> level=0, trace_valid=0, drop_cnt=0, halted=0, and a following store to 0x800 is captured normally.
